// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Lock supervisor and reset sequencer for a chain of PLLs. It synchronises the
// raw lock flags and holds the PLL chain in reset, retrying after a timeout. It
// qualifies lock over a stability window, then releases the downstream resets
// in staggered index order. Any lock loss after release restarts the whole
// sequence and is counted.
//
// Ports
//   clk_pin      in   board oscillator clock (sole clock)
//   rst_n        in   asynchronous active-low reset
//   locked_in    in   [NUM_PLL] raw PLL lock flags, asynchronous to clk_pin
//   clear_count  in   synchronous clear of loss_count
//   pll_rst      out  active-high reset request to the PLL chain
//   rst_n_out    out  [NUM_RST] active-low domain resets, bit 0 released first
//   all_locked   out  registered AND of the synchronised lock flags
//   ready        out  all resets released, state RUN
//   loss_count   out  [CNT_W] saturating count of losses in RELEASE/RUN
//   state        out  0 PLL_RESET, 1 WAIT_LOCK, 2 STABLE, 3 RELEASE, 4 RUN
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int unsigned NUM_PLL        = 2,
    parameter int unsigned NUM_RST        = 3,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned STAGGER_CYCLES = 8,
    parameter int unsigned CNT_W          = 8
) (
    input  logic               clk_pin,
    input  logic               rst_n,
    input  logic [NUM_PLL-1:0] locked_in,
    input  logic               clear_count,
    output logic               pll_rst,
    output logic [NUM_RST-1:0] rst_n_out,
    output logic               all_locked,
    output logic               ready,
    output logic [CNT_W-1:0]   loss_count,
    output logic [2:0]         state
);

    localparam logic [2:0] S_PLL_RESET = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    // One shared counter serves every state, so it is sized for the longest.
    localparam int unsigned MAX_A   = (PLL_RST_CYCLES > TIMEOUT_CYCLES) ? PLL_RST_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_B   = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    logic [SYNC_STAGES-1:0][NUM_PLL-1:0] r_sync;
    logic                                r_all_locked;
    logic [2:0]                          r_state;
    logic [CW-1:0]                       r_cnt;
    logic                                r_pll_rst;
    logic [NUM_RST-1:0]                  r_rst_n;
    logic                                r_ready;
    logic [CNT_W-1:0]                    r_loss;

    logic [NUM_RST-1:0]                  w_rst_next;
    logic                                w_all_rel;
    logic                                w_loss;

    // Lock synchronisers and registered AND.
    always_ff @(posedge clk_pin or negedge rst_n) begin
        if (!rst_n) begin
            r_sync       <= '0;
            r_all_locked <= 1'b0;
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], locked_in};
            r_all_locked <= &r_sync[SYNC_STAGES-1];
        end
    end

    // Releases happen strictly in index order, so the next release pattern is
    // the current one shifted up with a 1 entering at bit 0.
    always_comb begin
        w_rst_next    = '0;
        w_rst_next[0] = 1'b1;
        for (int unsigned i = 1; i < NUM_RST; i++) begin
            w_rst_next[i] = r_rst_n[i-1];
        end
        w_all_rel = &w_rst_next;
    end

    assign w_loss = ((r_state == S_RELEASE) || (r_state == S_RUN)) && !r_all_locked;

    always_ff @(posedge clk_pin or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_PLL_RESET;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_rst_n   <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_PLL_RESET: begin
                    r_pll_rst <= 1'b1;
                    r_rst_n   <= '0;
                    r_ready   <= 1'b0;
                    if (r_cnt == CW'(PLL_RST_CYCLES - 1)) begin
                        r_state   <= S_WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_all_locked) begin
                        r_state <= S_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= S_PLL_RESET;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!r_all_locked) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == CW'(STABLE_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_rst_n <= w_rst_next;
                        // With a single reset output RELEASE is skipped.
                        if (w_all_rel) begin
                            r_state <= S_RUN;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= S_RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!r_all_locked) begin
                        r_state   <= S_PLL_RESET;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        r_rst_n   <= '0;
                        r_ready   <= 1'b0;
                    end else if (r_cnt == CW'(STAGGER_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_rst_n <= w_rst_next;
                        if (w_all_rel) begin
                            r_state <= S_RUN;
                            r_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!r_all_locked) begin
                        r_state   <= S_PLL_RESET;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        r_rst_n   <= '0;
                        r_ready   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_PLL_RESET;
                    r_cnt     <= '0;
                    r_pll_rst <= 1'b1;
                    r_rst_n   <= '0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // Loss counter: a clear coinciding with a loss leaves exactly that loss.
    always_ff @(posedge clk_pin or negedge rst_n) begin
        if (!rst_n) begin
            r_loss <= '0;
        end else if (clear_count) begin
            r_loss <= w_loss ? CNT_W'(1) : '0;
        end else if (w_loss && (r_loss != '1)) begin
            r_loss <= r_loss + 1'b1;
        end
    end

    assign pll_rst    = r_pll_rst;
    assign rst_n_out  = r_rst_n;
    assign all_locked = r_all_locked;
    assign ready      = r_ready;
    assign loss_count = r_loss;
    assign state      = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Directed bench for pll_lock_supervisor with small timing parameters. A table
// of {inputs, edges to advance, expected outputs} covers bring-up, loss in RUN,
// relock and a clear; hand-written sequences cover timeout retry, a stability
// glitch, loss-count saturation with a coincident clear, and async reset
// mid-RELEASE. All inputs change and outputs are sampled 1 time unit after a
// rising edge.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    logic       clk_pin;
    logic       rst_n;
    logic [1:0] locked_in;
    logic       clear_count;
    logic       pll_rst;
    logic [2:0] rst_n_out;
    logic       all_locked;
    logic       ready;
    logic [1:0] loss_count;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    pll_lock_supervisor #(
        .NUM_PLL       (2),
        .NUM_RST       (3),
        .SYNC_STAGES   (2),
        .PLL_RST_CYCLES(4),
        .TIMEOUT_CYCLES(32),
        .STABLE_CYCLES (8),
        .STAGGER_CYCLES(2),
        .CNT_W         (2)
    ) dut (
        .clk_pin    (clk_pin),
        .rst_n      (rst_n),
        .locked_in  (locked_in),
        .clear_count(clear_count),
        .pll_rst    (pll_rst),
        .rst_n_out  (rst_n_out),
        .all_locked (all_locked),
        .ready      (ready),
        .loss_count (loss_count),
        .state      (state)
    );

    initial clk_pin = 1'b0;
    always #5 clk_pin = ~clk_pin;

    typedef struct {
        logic [1:0] lk;
        logic       clr;
        int         n;
        logic [2:0] st;
        logic       pll;
        logic [2:0] rn;
        logic       rdy;
        logic       al;
        logic [1:0] lc;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic pll,
                           input logic [2:0] rn, input logic rdy, input logic al,
                           input logic [1:0] lc);
        chk($sformatf("%s.state", tag), 32'(state), 32'(st));
        chk($sformatf("%s.pll_rst", tag), 32'(pll_rst), 32'(pll));
        chk($sformatf("%s.rst_n_out", tag), 32'(rst_n_out), 32'(rn));
        chk($sformatf("%s.ready", tag), 32'(ready), 32'(rdy));
        chk($sformatf("%s.all_locked", tag), 32'(all_locked), 32'(al));
        chk($sformatf("%s.loss_count", tag), 32'(loss_count), 32'(lc));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_pin);
        #1;
    endtask

    // Leaves the bench 1 unit after a rising edge with rst_n just released;
    // that edge is edge 0 of the following sequence.
    task automatic do_reset(input logic [1:0] lk);
        rst_n       = 1'b0;
        locked_in   = lk;
        clear_count = 1'b0;
        repeat (2) @(posedge clk_pin);
        #1;
        chk_all("reset", 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int k;
        k = 0;
        while (state !== s && k < budget) begin
            step(1);
            k++;
        end
        chk($sformatf("%s.wait_state", tag), 32'(state), 32'(s));
    endtask

    task automatic force_loss(input string tag);
        wait_state(tag, 3'd3, 100);
        locked_in = 2'b00;
        wait_state(tag, 3'd0, 20);
        locked_in = 2'b11;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        lk     clr   n   st    pll   rn      rdy   al    lc
        tbl[0]  = '{2'b00, 1'b0, 1, 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{2'b00, 1'b0, 2, 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{2'b00, 1'b0, 1, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{2'b00, 1'b0, 6, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0};
        tbl[4]  = '{2'b11, 1'b0, 2, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0};
        tbl[5]  = '{2'b11, 1'b0, 1, 3'd1, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0};
        tbl[6]  = '{2'b11, 1'b0, 1, 3'd2, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0};
        tbl[7]  = '{2'b11, 1'b0, 7, 3'd2, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0};
        tbl[8]  = '{2'b11, 1'b0, 1, 3'd3, 1'b0, 3'b001, 1'b0, 1'b1, 2'd0};
        tbl[9]  = '{2'b11, 1'b0, 1, 3'd3, 1'b0, 3'b001, 1'b0, 1'b1, 2'd0};
        tbl[10] = '{2'b11, 1'b0, 1, 3'd3, 1'b0, 3'b011, 1'b0, 1'b1, 2'd0};
        tbl[11] = '{2'b11, 1'b0, 1, 3'd3, 1'b0, 3'b011, 1'b0, 1'b1, 2'd0};
        tbl[12] = '{2'b11, 1'b0, 1, 3'd4, 1'b0, 3'b111, 1'b1, 1'b1, 2'd0};
        tbl[13] = '{2'b11, 1'b0, 5, 3'd4, 1'b0, 3'b111, 1'b1, 1'b1, 2'd0};
        tbl[14] = '{2'b01, 1'b0, 2, 3'd4, 1'b0, 3'b111, 1'b1, 1'b1, 2'd0};
        tbl[15] = '{2'b01, 1'b0, 1, 3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0};
        tbl[16] = '{2'b01, 1'b0, 1, 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd1};
        tbl[17] = '{2'b11, 1'b0, 3, 3'd0, 1'b1, 3'b000, 1'b0, 1'b1, 2'd1};
        tbl[18] = '{2'b11, 1'b0, 1, 3'd1, 1'b0, 3'b000, 1'b0, 1'b1, 2'd1};
        tbl[19] = '{2'b11, 1'b0, 1, 3'd2, 1'b0, 3'b000, 1'b0, 1'b1, 2'd1};
        tbl[20] = '{2'b11, 1'b0, 8, 3'd3, 1'b0, 3'b001, 1'b0, 1'b1, 2'd1};
        tbl[21] = '{2'b11, 1'b0, 4, 3'd4, 1'b0, 3'b111, 1'b1, 1'b1, 2'd1};
        tbl[22] = '{2'b11, 1'b1, 1, 3'd4, 1'b0, 3'b111, 1'b1, 1'b1, 2'd0};
        tbl[23] = '{2'b11, 1'b0, 2, 3'd4, 1'b0, 3'b111, 1'b1, 1'b1, 2'd0};

        // Nominal bring-up, loss in RUN, relock, clear alone.
        do_reset(2'b00);
        for (int i = 0; i < 24; i++) begin
            locked_in   = tbl[i].lk;
            clear_count = tbl[i].clr;
            step(tbl[i].n);
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].pll, tbl[i].rn,
                    tbl[i].rdy, tbl[i].al, tbl[i].lc);
        end
        clear_count = 1'b0;

        // Timeout retry: 4 cycles of pll_rst after every 32 WAIT_LOCK cycles.
        do_reset(2'b01);
        for (int k = 1; k <= 80; k++) begin
            step(1);
            chk($sformatf("timeout.pll_rst@%0d", k), 32'(pll_rst), 32'((k % 36) < 4));
        end
        chk("timeout.loss_count", 32'(loss_count), 32'd0);
        chk("timeout.rst_n_out", 32'(rst_n_out), 32'd0);

        // Stability glitch midway through STABLE.
        do_reset(2'b11);
        step(7);
        chk_all("glitch.e7", 3'd2, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0);
        locked_in = 2'b10;
        step(3);
        chk_all("glitch.e10", 3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0);
        locked_in = 2'b11;
        step(1);
        chk_all("glitch.e11", 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0);
        step(2);
        chk_all("glitch.e13", 3'd1, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0);
        step(1);
        chk_all("glitch.e14", 3'd2, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0);
        step(7);
        chk_all("glitch.e21", 3'd2, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0);
        step(1);
        chk_all("glitch.e22", 3'd3, 1'b0, 3'b001, 1'b0, 1'b1, 2'd0);

        // Saturation, then clear coinciding with a sixth loss, then clear alone.
        do_reset(2'b11);
        for (int i = 1; i <= 5; i++) begin
            force_loss($sformatf("sat%0d", i));
            chk($sformatf("sat%0d.loss_count", i), 32'(loss_count), 32'((i > 3) ? 3 : i));
        end
        wait_state("sat6", 3'd3, 100);
        locked_in = 2'b00;
        step(3);
        chk("sat6.all_locked", 32'(all_locked), 32'd0);
        clear_count = 1'b1;
        step(1);
        clear_count = 1'b0;
        chk("sat6.state", 32'(state), 32'd0);
        chk("sat6.loss_count", 32'(loss_count), 32'd1);
        clear_count = 1'b1;
        step(1);
        clear_count = 1'b0;
        chk("clear.loss_count", 32'(loss_count), 32'd0);

        // Async reset mid-RELEASE with a nonzero loss count.
        do_reset(2'b11);
        force_loss("async");
        chk("async.loss_before", 32'(loss_count), 32'd1);
        wait_state("async", 3'd3, 100);
        chk("async.rst_n_out0", 32'(rst_n_out), 32'b001);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async.immediate", 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0);
        @(posedge clk_pin);
        #1;
        chk_all("async.held", 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        step(3);
        chk_all("async.e3", 3'd0, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0);
        step(10);
        chk_all("async.e13", 3'd3, 1'b0, 3'b001, 1'b0, 1'b1, 2'd0);
        step(4);
        chk_all("async.e17", 3'd4, 1'b0, 3'b111, 1'b1, 1'b1, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Parametrised lock supervisor and reset sequencer for chained PLLs. Watches NUM_PLL asynchronous lock signals from the board oscillator domain. Drives the PLL chain reset with timeout retry, and qualifies lock over a stability window. Releases NUM_RST downstream resets in staggered order, then re-enters reset on any lock loss while counting loss events. It sits next to the PLL chain at the top level and replaces ad-hoc use of the raw `locked` output.

## Interface
- NUM_PLL, 2: number of lock inputs (≥1)
- NUM_RST, 3: number of sequenced reset outputs (≥1)
- SYNC_STAGES, 2: synchroniser depth on each lock input (≥2)
- PLL_RST_CYCLES, 16: pll_rst pulse length in cycles (≥1)
- TIMEOUT_CYCLES, 65536: WAIT_LOCK cycles before the PLL is reset again (≥1)
- STABLE_CYCLES, 1024: consecutive locked cycles required before release (≥1)
- STAGGER_CYCLES, 8: cycles between successive reset releases (≥1)
- CNT_W, 8: loss_count width
- clk_pin  in  1  board oscillator clock; sole clock of the block
- rst_n  in  1  asynchronous, active-low reset
- locked_in  in  NUM_PLL  raw PLL lock flags, asynchronous to clk_pin
- clear_count  in  1  synchronous clear of loss_count
- pll_rst  out  1  active-high reset request to the PLL chain
- rst_n_out  out  NUM_RST  active-low domain resets, released in index order 0 first
- all_locked  out  1  AND of the synchronised lock flags
- ready  out  1  all rst_n_out released, state RUN
- loss_count  out  CNT_W  saturating count of lock losses seen in RELEASE/RUN
- state  out  3  0 PLL_RESET, 1 WAIT_LOCK, 2 STABLE, 3 RELEASE, 4 RUN

## Operation
- Each locked_in bit passes through its own SYNC_STAGES-flop synchroniser. all_locked is registered as the AND of the synchroniser outputs.
- **PLL_RESET**: pll_rst=1 and all rst_n_out=0. A counter runs for PLL_RST_CYCLES cycles, then the block moves to WAIT_LOCK and pll_rst goes to 0.
- **WAIT_LOCK**: the timeout counter increments every cycle.
  - all_locked=1 moves the block to STABLE.
  - If the counter reaches TIMEOUT_CYCLES with no lock, the block moves to PLL_RESET. This is not counted as a loss.
- **STABLE**: counts consecutive cycles with all_locked=1.
  - all_locked=0 moves the block to WAIT_LOCK with the timeout restarted. No pll_rst is issued and no loss is counted.
  - When the count reaches STABLE_CYCLES, the block moves to RELEASE.
- **RELEASE**: rst_n_out[0] rises on the edge that leaves STABLE, and rst_n_out[i] rises STAGGER_CYCLES·i edges later. Released bits stay high.
- **RUN**: entered on the edge that raises rst_n_out[NUM_RST-1]. ready=1 on that same edge. When NUM_RST=1, RELEASE lasts zero cycles and the block goes straight to RUN.
- **Loss**: all_locked=0 while in RELEASE or RUN has these effects on the next edge:
  - all rst_n_out=0, ready=0, pll_rst=1
  - state becomes PLL_RESET
  - loss_count increments
- loss_count saturates at 2^CNT_W−1. If clear_count and an increment happen in the same cycle, loss_count becomes 1. clear_count alone sets loss_count to 0.
- Every counter is cleared on each state entry.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state=PLL_RESET, pll_rst=1
  - rst_n_out=all 0, ready=0, all_locked=0
  - loss_count=0, synchronisers=0, counters=0
- rst_n is asserted asynchronously at any point, including mid-RELEASE or in RUN. Outputs take their reset values immediately, and the loss count is not incremented.
- After rst_n deasserts, pll_rst stays 1 for exactly PLL_RST_CYCLES rising edges.
- Latency from a locked_in change to all_locked: SYNC_STAGES+1 edges.
- From all_locked rising in WAIT_LOCK to rst_n_out[0] rising: 1+STABLE_CYCLES edges, provided lock holds throughout.
- rst_n_out[NUM_RST-1] and ready rise STAGGER_CYCLES·(NUM_RST−1) edges after rst_n_out[0].
- From all_locked falling in RUN to rst_n_out=0: 1 edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Consumers of rst_n_out in other clock domains must resynchronise it locally. The assert side of that resynchroniser is asynchronous.

## Test plan
Bench parameters: NUM_PLL=2, NUM_RST=3, SYNC_STAGES=2, PLL_RST_CYCLES=4, TIMEOUT_CYCLES=32, STABLE_CYCLES=8, STAGGER_CYCLES=2, CNT_W=2.
- **Nominal bring-up**: release rst_n, then raise both locked_in at cycle 10.
  - pll_rst is high for 4 cycles.
  - all_locked is high 3 edges after the inputs rise.
  - rst_n_out[0] rises 9 edges after all_locked, rst_n_out[1] 2 edges later, rst_n_out[2] and ready 4 edges later.
  - loss_count=0.
- **Timeout retry**: hold locked_in[1]=0 throughout. pll_rst pulses for 4 cycles after every 32 WAIT_LOCK cycles, and loss_count stays 0.
- **Stability glitch**: drop locked_in[0] for 3 cycles midway through STABLE. State returns to WAIT_LOCK, pll_rst stays 0, and the full 8-cycle window restarts after relock.
- **Loss in RUN**: drop locked_in[1] once the block is in RUN.
  - rst_n_out=000, ready=0 and pll_rst=1 one edge after all_locked falls.
  - loss_count=1, and the sequence repeats on relock.
- **Saturation and clear**: force 5 losses and check loss_count=3. Then assert clear_count in the same cycle as a sixth loss and check loss_count=1.
- **Async reset mid-RELEASE**: pull rst_n low after rst_n_out[0] has risen. All outputs go to their reset values at once, loss_count=0, and a full bring-up follows.
